// File: rtl/lsu_pkg.sv
// Shared state encoding, op constants and helpers for the load/store unit.
// The optional misaligned-access trap in lsu_ctrl is enabled by defining LSU_MISALIGN_TRAP_EN.
package lsu_pkg;

  localparam int INST_TYPE_W = 3;
  localparam logic [INST_TYPE_W-1:0] INST_NONE  = 3'd0;
  localparam logic [INST_TYPE_W-1:0] INST_LOAD  = 3'd1;
  localparam logic [INST_TYPE_W-1:0] INST_STORE = 3'd2;

  localparam int LSU_WSTRB_W = 8;

  // funct3 encodings; stores only use the B/H/W codes, anything else is a word access
  localparam logic [2:0] MEM_B  = 3'd0;
  localparam logic [2:0] MEM_H  = 3'd1;
  localparam logic [2:0] MEM_W  = 3'd2;
  localparam logic [2:0] MEM_BU = 3'd4;
  localparam logic [2:0] MEM_HU = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_AR    = 3'd1,
    ST_R     = 3'd2,
    ST_STORE = 3'd3,
    ST_DONE  = 3'd4
  } lsu_state_e;

  function automatic logic access_misaligned(input logic is_store, input logic [2:0] op,
                                             input logic [1:0] addr_lo);
    logic mis;
    case (op)
      MEM_B:   mis = 1'b0;
      MEM_H:   mis = addr_lo[0];
      MEM_BU:  mis = is_store ? (addr_lo != 2'b00) : 1'b0;
      MEM_HU:  mis = is_store ? (addr_lo != 2'b00) : addr_lo[0];
      default: mis = (addr_lo != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane logic: load extract with sign/zero extension and store lane shift/strobe.
// Misaligned halfwords/words simply use the low address bits, so straddling data is truncated.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int WSTRB_W = LSU_WSTRB_W
) (
  input  logic [2:0]         mem_op_i,
  input  logic [1:0]         addr_lo_i,
  input  logic [DATA_W-1:0]  rdata_i,
  input  logic [DATA_W-1:0]  sdata_i,
  output logic [DATA_W-1:0]  load_data_o,
  output logic [DATA_W-1:0]  wdata_o,
  output logic [WSTRB_W-1:0] wstrb_o
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic [3:0]  lane_strb;

  always_comb begin
    byte_lane = 8'(rdata_i >> {addr_lo_i, 3'b000});
    half_lane = 16'(rdata_i >> {addr_lo_i[1], 4'b0000});
    case (mem_op_i)
      MEM_B:   load_data_o = {{(DATA_W-8){byte_lane[7]}}, byte_lane};
      MEM_H:   load_data_o = {{(DATA_W-16){half_lane[15]}}, half_lane};
      MEM_BU:  load_data_o = {{(DATA_W-8){1'b0}}, byte_lane};
      MEM_HU:  load_data_o = {{(DATA_W-16){1'b0}}, half_lane};
      default: load_data_o = rdata_i;
    endcase

    case (mem_op_i)
      MEM_B: begin
        lane_strb = 4'b0001 << addr_lo_i;
        wdata_o   = {{(DATA_W-8){1'b0}}, sdata_i[7:0]} << {addr_lo_i, 3'b000};
      end
      MEM_H: begin
        lane_strb = 4'b0011 << {addr_lo_i[1], 1'b0};
        wdata_o   = {{(DATA_W-16){1'b0}}, sdata_i[15:0]} << {addr_lo_i[1], 4'b0000};
      end
      default: begin
        lane_strb = 4'b1111;
        wdata_o   = sdata_i;
      end
    endcase
    wstrb_o = {{(WSTRB_W-4){1'b0}}, lane_strb};
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store control stage: takes one op from execute, runs the dsram read or write, hands the result to write-back.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned halfword/word accesses instead of issuing them to dsram.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int WSTRB_W = LSU_WSTRB_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   valid_i,
  output logic                   ready_o,
  input  logic [INST_TYPE_W-1:0] inst_type_i,
  input  logic [2:0]             mem_op_i,
  input  logic [ADDR_W-1:0]      addr_i,
  input  logic [DATA_W-1:0]      sdata_i,
  input  logic [DATA_W-1:0]      alu_res_i,
  input  logic [ADDR_W-1:0]      pc_i,
  output logic                   arvalid_o,
  input  logic                   arready_i,
  input  logic                   rvalid_i,
  output logic                   rready_o,
  input  logic [DATA_W-1:0]      rdata_i,
  output logic [ADDR_W-1:0]      raddr_o,
  output logic [INST_TYPE_W-1:0] inst_type_o,
  output logic [ADDR_W-1:0]      awaddr_o,
  output logic [DATA_W-1:0]      wdata_o,
  output logic [WSTRB_W-1:0]     wstrb_o,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic [DATA_W-1:0]      wb_data_o,
  output logic [ADDR_W-1:0]      pc_o,
  output logic                   misalign_o
);

  lsu_state_e             state_q, state_d;
  logic [2:0]             op_q, op_d;
  logic [1:0]             addr_lo_q, addr_lo_d;
  logic                   ready_q, ready_d;
  logic                   arvalid_q, arvalid_d;
  logic                   rready_q, rready_d;
  logic                   valid_q, valid_d;
  logic                   misalign_q, misalign_d;
  logic [ADDR_W-1:0]      raddr_q, raddr_d;
  logic [ADDR_W-1:0]      awaddr_q, awaddr_d;
  logic [ADDR_W-1:0]      pc_q, pc_d;
  logic [INST_TYPE_W-1:0] inst_type_q, inst_type_d;
  logic [DATA_W-1:0]      wdata_q, wdata_d;
  logic [DATA_W-1:0]      wb_data_q, wb_data_d;
  logic [WSTRB_W-1:0]     wstrb_q, wstrb_d;

  logic                   idle;
  logic                   trap;
  logic [2:0]             align_op;
  logic [1:0]             align_addr;
  logic [ADDR_W-1:0]      word_addr;
  logic [DATA_W-1:0]      load_data;
  logic [DATA_W-1:0]      store_data;
  logic [WSTRB_W-1:0]     store_strb;

  // The aligner sees the incoming op in IDLE (store lanes registered at accept), the latched load otherwise.
  assign idle       = (state_q == ST_IDLE);
  assign align_op   = idle ? mem_op_i : op_q;
  assign align_addr = idle ? addr_i[1:0] : addr_lo_q;
  assign word_addr  = {addr_i[ADDR_W-1:2], 2'b00};

  lsu_align #(
    .DATA_W (DATA_W),
    .WSTRB_W(WSTRB_W)
  ) u_align (
    .mem_op_i   (align_op),
    .addr_lo_i  (align_addr),
    .rdata_i    (rdata_i),
    .sdata_i    (sdata_i),
    .load_data_o(load_data),
    .wdata_o    (store_data),
    .wstrb_o    (store_strb)
  );

`ifdef LSU_MISALIGN_TRAP_EN
  assign trap = ((inst_type_i == INST_LOAD)  && access_misaligned(1'b0, mem_op_i, addr_i[1:0])) ||
                ((inst_type_i == INST_STORE) && access_misaligned(1'b1, mem_op_i, addr_i[1:0]));
`else
  assign trap = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    addr_lo_d   = addr_lo_q;
    ready_d     = ready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    valid_d     = valid_q;
    misalign_d  = misalign_q;
    raddr_d     = raddr_q;
    awaddr_d    = awaddr_q;
    pc_d        = pc_q;
    inst_type_d = inst_type_q;
    wdata_d     = wdata_q;
    wb_data_d   = wb_data_q;
    wstrb_d     = wstrb_q;

    case (state_q)
      ST_IDLE: begin
        if (valid_i) begin
          op_d      = mem_op_i;
          addr_lo_d = addr_i[1:0];
          pc_d      = pc_i;
          ready_d   = 1'b0;
          if (trap) begin
            state_d    = ST_DONE;
            valid_d    = 1'b1;
            misalign_d = 1'b1;
            wb_data_d  = '0;
          end else if (inst_type_i == INST_LOAD) begin
            state_d   = ST_AR;
            arvalid_d = 1'b1;
            raddr_d   = word_addr;
          end else if (inst_type_i == INST_STORE) begin
            state_d     = ST_STORE;
            inst_type_d = INST_STORE;
            awaddr_d    = word_addr;
            wdata_d     = store_data;
            wstrb_d     = store_strb;
          end else begin
            state_d   = ST_DONE;
            valid_d   = 1'b1;
            wb_data_d = alu_res_i;
          end
        end
      end
      // Read data arriving alongside the address handshake is ignored; only R samples rdata.
      ST_AR: begin
        if (arready_i) begin
          state_d   = ST_R;
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
        end
      end
      ST_R: begin
        if (rvalid_i) begin
          state_d   = ST_DONE;
          rready_d  = 1'b0;
          valid_d   = 1'b1;
          wb_data_d = load_data;
        end
      end
      ST_STORE: begin
        state_d     = ST_DONE;
        inst_type_d = INST_NONE;
        wstrb_d     = '0;
        valid_d     = 1'b1;
        wb_data_d   = '0;
      end
      ST_DONE: begin
        if (ready_i) begin
          state_d    = ST_IDLE;
          valid_d    = 1'b0;
          misalign_d = 1'b0;
          ready_d    = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      op_q        <= '0;
      addr_lo_q   <= '0;
      ready_q     <= 1'b1;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      valid_q     <= 1'b0;
      misalign_q  <= 1'b0;
      raddr_q     <= '0;
      awaddr_q    <= '0;
      pc_q        <= '0;
      inst_type_q <= INST_NONE;
      wdata_q     <= '0;
      wb_data_q   <= '0;
      wstrb_q     <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      addr_lo_q   <= addr_lo_d;
      ready_q     <= ready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      valid_q     <= valid_d;
      misalign_q  <= misalign_d;
      raddr_q     <= raddr_d;
      awaddr_q    <= awaddr_d;
      pc_q        <= pc_d;
      inst_type_q <= inst_type_d;
      wdata_q     <= wdata_d;
      wb_data_q   <= wb_data_d;
      wstrb_q     <= wstrb_d;
    end
  end

  assign ready_o     = ready_q;
  assign arvalid_o   = arvalid_q;
  assign rready_o    = rready_q;
  assign valid_o     = valid_q;
  assign misalign_o  = misalign_q;
  assign raddr_o     = raddr_q;
  assign awaddr_o    = awaddr_q;
  assign pc_o        = pc_q;
  assign inst_type_o = inst_type_q;
  assign wdata_o     = wdata_q;
  assign wb_data_o   = wb_data_q;
  assign wstrb_o     = wstrb_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl: stimulus pushes expected write-back and store results, a monitor pops and compares.
// Misaligned-word expectations follow LSU_MISALIGN_TRAP_EN, matching however the design is built.
module tb_lsu_ctrl;
  import lsu_pkg::*;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   valid_i;
  logic                   ready_o;
  logic [INST_TYPE_W-1:0] inst_type_i;
  logic [2:0]             mem_op_i;
  logic [31:0]            addr_i, sdata_i, alu_res_i, pc_i;
  logic                   arvalid_o, arready_i, rvalid_i, rready_o;
  logic [31:0]            rdata_i, raddr_o;
  logic [INST_TYPE_W-1:0] inst_type_o;
  logic [31:0]            awaddr_o, wdata_o;
  logic [7:0]             wstrb_o;
  logic                   valid_o, ready_i;
  logic [31:0]            wb_data_o, pc_o;
  logic                   misalign_o;

  always #5 clk = ~clk;

  lsu_ctrl dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o),
    .inst_type_i(inst_type_i), .mem_op_i(mem_op_i), .addr_i(addr_i),
    .sdata_i(sdata_i), .alu_res_i(alu_res_i), .pc_i(pc_i),
    .arvalid_o(arvalid_o), .arready_i(arready_i), .rvalid_i(rvalid_i),
    .rready_o(rready_o), .rdata_i(rdata_i), .raddr_o(raddr_o),
    .inst_type_o(inst_type_o), .awaddr_o(awaddr_o), .wdata_o(wdata_o),
    .wstrb_o(wstrb_o), .valid_o(valid_o), .ready_i(ready_i),
    .wb_data_o(wb_data_o), .pc_o(pc_o), .misalign_o(misalign_o)
  );

  typedef struct {
    logic [31:0] data;
    logic [31:0] pc;
    logic        mis;
  } wbExp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] mask;
    logic [7:0]  strb;
  } stExp_t;

  wbExp_t wbQ[$];
  stExp_t stQ[$];
  int testsRun = 0;
  int testsFailed = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Monitor: every write-back handshake and every store cycle is matched against the scoreboard.
  initial begin
    wbExp_t we;
    stExp_t se;
    forever begin
      @(negedge clk);
      if (rst && valid_o && ready_i) begin
        if (wbQ.size() == 0) begin
          checkOutput("unexpected valid_o", 32'(valid_o), 32'd0);
        end else begin
          we = wbQ.pop_front();
          checkOutput("wb_data_o", wb_data_o, we.data);
          checkOutput("pc_o", pc_o, we.pc);
          checkOutput("misalign_o", 32'(misalign_o), 32'(we.mis));
        end
      end
      if (rst && inst_type_o == INST_STORE) begin
        if (stQ.size() == 0) begin
          checkOutput("extra store cycle", 32'(inst_type_o), 32'(INST_NONE));
        end else begin
          se = stQ.pop_front();
          checkOutput("awaddr_o", awaddr_o, se.addr);
          checkOutput("wdata_o lanes", wdata_o & se.mask, se.data & se.mask);
          checkOutput("wstrb_o", 32'(wstrb_o), 32'(se.strb));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, %0d tests run", testsRun);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic waitIdle(input string name);
    int guard = 0;
    while (!ready_o && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!ready_o) checkOutput(name, 32'(ready_o), 32'd1);
  endtask

  task automatic applyStimulus(input logic [2:0] iType, input logic [2:0] op, input logic [31:0] addr,
                               input logic [31:0] sdata, input logic [31:0] alu, input logic [31:0] pc);
    waitIdle("ready_o before issue");
    inst_type_i = iType;
    mem_op_i    = op;
    addr_i      = addr;
    sdata_i     = sdata;
    alu_res_i   = alu;
    pc_i        = pc;
    valid_i     = 1'b1;
    @(posedge clk); #1;
    valid_i     = 1'b0;
    inst_type_i = INST_NONE;
    mem_op_i    = '0;
    addr_i      = '0;
    sdata_i     = '0;
    alu_res_i   = '0;
    pc_i        = '0;
  endtask

  task automatic runLoad(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] rdata,
                         input logic [31:0] expData, input logic [31:0] pc, input int arDelay,
                         input int wbHold, input bit rdataOnAr);
    wbExp_t e;
    e.data = expData;
    e.pc   = pc;
    e.mis  = 1'b0;
    wbQ.push_back(e);
    if (wbHold > 0) ready_i = 1'b0;
    applyStimulus(INST_LOAD, op, addr, 32'h0, 32'hDEAD0000, pc);
    checkOutput("arvalid_o", 32'(arvalid_o), 32'd1);
    checkOutput("raddr_o", raddr_o, {addr[31:2], 2'b00});
    for (int i = 0; i < arDelay; i++) begin
      @(posedge clk); #1;
      checkOutput("arvalid_o held", 32'(arvalid_o), 32'd1);
      checkOutput("raddr_o held", raddr_o, {addr[31:2], 2'b00});
      checkOutput("ready_o busy in AR", 32'(ready_o), 32'd0);
    end
    arready_i = 1'b1;
    if (rdataOnAr) begin
      rvalid_i = 1'b1;
      rdata_i  = ~rdata;
    end
    @(posedge clk); #1;
    arready_i = 1'b0;
    rvalid_i  = 1'b1;
    rdata_i   = rdata;
    checkOutput("arvalid_o after handshake", 32'(arvalid_o), 32'd0);
    checkOutput("rready_o in R", 32'(rready_o), 32'd1);
    @(posedge clk); #1;
    rvalid_i = 1'b0;
    rdata_i  = '0;
    for (int i = 0; i < wbHold; i++) begin
      checkOutput("valid_o held", 32'(valid_o), 32'd1);
      checkOutput("wb_data_o held", wb_data_o, expData);
      checkOutput("ready_o busy in DONE", 32'(ready_o), 32'd0);
      @(posedge clk); #1;
    end
    ready_i = 1'b1;
    waitIdle("load return to idle");
  endtask

  task automatic runStore(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                          input logic [31:0] expData, input logic [31:0] mask, input logic [7:0] strb,
                          input logic [31:0] pc);
    stExp_t s;
    wbExp_t e;
    s.addr = {addr[31:2], 2'b00};
    s.data = expData;
    s.mask = mask;
    s.strb = strb;
    stQ.push_back(s);
    e.data = 32'h0;
    e.pc   = pc;
    e.mis  = 1'b0;
    wbQ.push_back(e);
    applyStimulus(INST_STORE, op, addr, sdata, 32'hDEAD0000, pc);
    @(posedge clk); #1;
    checkOutput("inst_type_o after store cycle", 32'(inst_type_o), 32'(INST_NONE));
    waitIdle("store return to idle");
  endtask

  task automatic runOther(input logic [31:0] alu, input logic [31:0] pc);
    wbExp_t e;
    e.data = alu;
    e.pc   = pc;
    e.mis  = 1'b0;
    wbQ.push_back(e);
    applyStimulus(INST_NONE, MEM_W, 32'h8000_0002, 32'h5555_5555, alu, pc);
    checkOutput("arvalid_o on alu op", 32'(arvalid_o), 32'd0);
    waitIdle("alu op return to idle");
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, " ready_o"}, 32'(ready_o), 32'd1);
    checkOutput({tag, " arvalid_o"}, 32'(arvalid_o), 32'd0);
    checkOutput({tag, " rready_o"}, 32'(rready_o), 32'd0);
    checkOutput({tag, " valid_o"}, 32'(valid_o), 32'd0);
    checkOutput({tag, " misalign_o"}, 32'(misalign_o), 32'd0);
    checkOutput({tag, " inst_type_o"}, 32'(inst_type_o), 32'd0);
    checkOutput({tag, " wstrb_o"}, 32'(wstrb_o), 32'd0);
    checkOutput({tag, " wdata_o"}, wdata_o, 32'd0);
    checkOutput({tag, " awaddr_o"}, awaddr_o, 32'd0);
    checkOutput({tag, " wb_data_o"}, wb_data_o, 32'd0);
    checkOutput({tag, " pc_o"}, pc_o, 32'd0);
  endtask

  initial begin
    rst = 1'b0;
    valid_i = 1'b0; inst_type_i = INST_NONE; mem_op_i = '0; addr_i = '0;
    sdata_i = '0; alu_res_i = '0; pc_i = '0;
    arready_i = 1'b0; rvalid_i = 1'b0; rdata_i = '0; ready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkResetOutputs("reset");
    rst = 1'b1;
    @(posedge clk); #1;

    runLoad(MEM_B,  32'h8000_0003, 32'h80FF_1234, 32'hFFFF_FF80, 32'h0000_1000, 0, 0, 1'b0);
    runLoad(MEM_HU, 32'h8000_0002, 32'hBEEF_0000, 32'h0000_BEEF, 32'h0000_1004, 1, 0, 1'b0);
    runLoad(MEM_H,  32'h8000_0002, 32'hBEEF_0000, 32'hFFFF_BEEF, 32'h0000_1008, 0, 0, 1'b1);
    runLoad(MEM_BU, 32'h8000_0001, 32'h80FF_1234, 32'h0000_0012, 32'h0000_100C, 0, 0, 1'b0);
    runLoad(MEM_H,  32'h8000_0000, 32'h0001_7FFF, 32'h0000_7FFF, 32'h0000_1010, 0, 0, 1'b0);
    runLoad(3'd3,   32'h8000_0004, 32'h1122_3344, 32'h1122_3344, 32'h0000_1014, 0, 0, 1'b0);
    runLoad(MEM_W,  32'h8000_0010, 32'h0BAD_F00D, 32'h0BAD_F00D, 32'h0000_1018, 5, 3, 1'b0);

    runStore(MEM_B, 32'h8000_0001, 32'h0000_00AB, 32'h0000_AB00, 32'h0000_FF00, 8'h02, 32'h0000_2000);
    runStore(MEM_H, 32'h8000_0002, 32'h1234_ABCD, 32'hABCD_0000, 32'hFFFF_0000, 8'h0C, 32'h0000_2004);
    runStore(MEM_W, 32'h8000_0004, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 8'h0F, 32'h0000_2008);
    runStore(3'd6,  32'h8000_0008, 32'hCAFE_F00D, 32'hCAFE_F00D, 32'hFFFF_FFFF, 8'h0F, 32'h0000_200C);

    runOther(32'h1234_5678, 32'h0000_3000);

`ifdef LSU_MISALIGN_TRAP_EN
    begin
      wbExp_t e;
      e.data = 32'h0;
      e.pc   = 32'h0000_4000;
      e.mis  = 1'b1;
      wbQ.push_back(e);
      applyStimulus(INST_LOAD, MEM_W, 32'h8000_0002, 32'h0, 32'h0, 32'h0000_4000);
      checkOutput("trap arvalid_o", 32'(arvalid_o), 32'd0);
      checkOutput("trap valid_o", 32'(valid_o), 32'd1);
      waitIdle("trap return to idle");
    end
`else
    runLoad(MEM_W, 32'h8000_0002, 32'hCAFE_BABE, 32'hCAFE_BABE, 32'h0000_4000, 0, 0, 1'b0);
`endif

    // Reset while waiting in R abandons the read; the next op must run normally.
    applyStimulus(INST_LOAD, MEM_B, 32'h8000_0020, 32'h0, 32'h0, 32'h0000_5000);
    arready_i = 1'b1;
    @(posedge clk); #1;
    arready_i = 1'b0;
    checkOutput("rready_o before reset", 32'(rready_o), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkResetOutputs("mid-op reset");
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    runLoad(MEM_W, 32'h8000_0024, 32'h7654_3210, 32'h7654_3210, 32'h0000_5004, 2, 1, 1'b0);

    repeat (2) @(posedge clk);
    #1;
    checkOutput("scoreboard drained", 32'(wbQ.size() + stQ.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
